// File: rtl/nvs_pkg.sv
// Shared types and default sizes for the nearest-value scheduler.
package nvs_pkg;

  localparam int NVS_WIDTH = 8;
  localparam int NVS_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/abs_distance.sv
// Combinational unsigned |a - b|: the smaller operand is always subtracted
// from the larger one, so the result never wraps.
module abs_distance #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] dist_o
);

  // Compare first, then subtract in the non-wrapping direction
  always_comb begin
    dist_o = '0;
    if (a_i >= b_i) dist_o = a_i - b_i;
    else            dist_o = b_i - a_i;
  end

endmodule

// File: rtl/nearest_value_scheduler.sv
// Streams candidates one per clock through a single shared distance unit
// and keeps the earliest candidate with the smallest distance to the
// reference. The result is held on a valid/ready output until taken.
module nearest_value_scheduler
  import nvs_pkg::*;
#(
  parameter int WIDTH = NVS_WIDTH,
  parameter int CNT_W = NVS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ref_in,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_dist,
  output logic [CNT_W-1:0] out_index,
  output logic             found,
  output logic             busy
);

  state_t           state_q;
  logic [WIDTH-1:0] ref_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] best_data_q;
  logic [WIDTH-1:0] best_dist_q;
  logic [CNT_W-1:0] best_idx_q;
  logic             found_q;

  logic [WIDTH-1:0] dist_d;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             last_d;
  logic             better_d;

  // One distance unit shared by every candidate of the job
  abs_distance #(.WIDTH(WIDTH)) u_abs_distance (
    .a_i   (in_data),
    .b_i   (ref_q),
    .dist_o(dist_d)
  );

  // The first candidate always wins; later ones only on a strictly smaller
  // distance, so ties keep the earlier arrival.
  always_comb begin
    cnt_inc_d = cnt_q + 1'b1;
    last_d    = (cnt_inc_d == len_q);
    better_d  = (cnt_q == '0) || (dist_d < best_dist_q);
  end

  // Job FSM with capture, candidate counter and best-so-far registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ref_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      best_data_q <= '0;
      best_dist_q <= '0;
      best_idx_q  <= '0;
      found_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            ref_q       <= ref_in;
            len_q       <= len;
            cnt_q       <= '0;
            best_data_q <= '0;
            best_dist_q <= '0;
            best_idx_q  <= '0;
            found_q     <= 1'b0;
            state_q     <= (len != '0) ? ST_SCAN : ST_DONE;
          end
        end
        ST_SCAN: begin
          if (in_valid) begin
            if (better_d) begin
              best_data_q <= in_data;
              best_dist_q <= dist_d;
              best_idx_q  <= cnt_q;
            end
            found_q <= 1'b1;
            cnt_q   <= cnt_inc_d;
            if (last_d) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake flags come straight from the state register
  assign in_ready  = (state_q == ST_SCAN);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = best_data_q;
  assign out_dist  = best_dist_q;
  assign out_index = best_idx_q;
  assign found     = found_q;

endmodule

// File: tb/tb_nearest_value_scheduler.sv
// Bench for nearest_value_scheduler: directed vector table, reset abort
// sequence and randomized jobs checked against a two-pass reference model.
module tb_nearest_value_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] ref_in;
  logic [3:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_dist;
  logic [3:0] out_index;
  logic       found;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct {
    logic [7:0] r;
    logic [3:0] n;
    logic [7:0] c0, c1, c2, c3;
    int         mode;
    int         bp;
    bit         sp;
    logic [7:0] ed;
    logic [7:0] edist;
    logic [3:0] ei;
    logic       ef;
  } vec_t;

  vec_t tbl [6];

  nearest_value_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ref_in   (ref_in),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_dist (out_dist),
    .out_index(out_index),
    .found    (found),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: smallest distance over the whole job, then earliest holder of it
  task automatic model(input logic [7:0] r, input int n, input logic [7:0] c[16],
                       output logic [7:0] ed, output logic [7:0] edist,
                       output logic [3:0] ei, output logic ef);
    int mind;
    int d;
    ed = 8'h00; edist = 8'h00; ei = 4'h0; ef = 1'b0;
    if (n != 0) begin
      mind = 1000;
      for (int i = 0; i < n; i++) begin
        d = (int'(c[i]) > int'(r)) ? int'(c[i]) - int'(r) : int'(r) - int'(c[i]);
        if (d < mind) mind = d;
      end
      for (int i = n - 1; i >= 0; i--) begin
        d = (int'(c[i]) > int'(r)) ? int'(c[i]) - int'(r) : int'(r) - int'(c[i]);
        if (d == mind) begin
          ed = c[i]; ei = 4'(i);
        end
      end
      edist = 8'(mind);
      ef    = 1'b1;
    end
  endtask

  // Called 1 time unit after a rising edge with the block in IDLE.
  // mode: 0 = in_valid held high, 1 = fixed stall pattern, 2 = random stalls
  task automatic run_job(input string tag, input logic [7:0] r, input logic [3:0] n,
                         input logic [7:0] c[16], input int mode, input int bp, input bit sp,
                         output logic [7:0] od, output logic [7:0] odist,
                         output logic [3:0] oi, output logic of);
    int idx;
    int lat;
    bit acc;
    start = 1'b1; ref_in = r; len = n;
    @(posedge clk); #1;
    start  = sp;
    ref_in = ~r;
    len    = 4'hF;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    check({tag, " in_ready_after_start"}, 32'(in_ready), 32'(n != 0));
    idx = 0;
    lat = 0;
    while (!out_valid && lat < 300) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = pat[lat % 6];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = (in_valid && idx < 16) ? c[idx] : 8'($urandom);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      lat++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check({tag, " out_valid_reached"}, 32'(out_valid), 32'd1);
    check({tag, " accepted_count"}, 32'(idx), 32'(n));
    if (mode == 0) check({tag, " latency_edges"}, 32'(lat), 32'(n));
    od = out_data; odist = out_dist; oi = out_index; of = found;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      check({tag, " hold_stable"}, {out_valid, out_data, out_dist, out_index, found},
            {1'b1, od, odist, oi, of});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " idle_after_handshake"}, {busy, out_valid, in_ready}, 3'b000);
  endtask

  initial begin
    logic [7:0] c [16];
    logic [7:0] od, odist, ed, edist;
    logic [3:0] oi, ei;
    logic       of, ef;
    int         n;
    int         mode;

    tbl[0] = '{8'h40, 4'd4, 8'h10, 8'h45, 8'h3A, 8'h80, 0, 0, 1'b0, 8'h45, 8'h05, 4'd1, 1'b1};
    tbl[1] = '{8'h20, 4'd3, 8'h1C, 8'h24, 8'h1C, 8'h00, 0, 0, 1'b0, 8'h1C, 8'h04, 4'd0, 1'b1};
    tbl[2] = '{8'h00, 4'd2, 8'hFF, 8'h01, 8'h00, 8'h00, 0, 0, 1'b0, 8'h01, 8'h01, 4'd1, 1'b1};
    tbl[3] = '{8'hFF, 4'd1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1'b0, 8'h00, 8'hFF, 4'd0, 1'b1};
    tbl[4] = '{8'h80, 4'd3, 8'h70, 8'h85, 8'h7F, 8'h00, 1, 5, 1'b1, 8'h7F, 8'h01, 4'd2, 1'b1};
    tbl[5] = '{8'h33, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 3, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0};

    rst = 1'b1; start = 1'b0; ref_in = 8'h00; len = 4'h0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, in_ready, busy, found, out_data, out_dist, out_index}, 29'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) c[i] = 8'h00;
      c[0] = tbl[t].c0; c[1] = tbl[t].c1; c[2] = tbl[t].c2; c[3] = tbl[t].c3;
      run_job($sformatf("vec%0d", t), tbl[t].r, tbl[t].n, c, tbl[t].mode, tbl[t].bp,
              tbl[t].sp, od, odist, oi, of);
      check($sformatf("vec%0d out_data", t), 32'(od), 32'(tbl[t].ed));
      check($sformatf("vec%0d out_dist", t), 32'(odist), 32'(tbl[t].edist));
      check($sformatf("vec%0d out_index", t), 32'(oi), 32'(tbl[t].ei));
      check($sformatf("vec%0d found", t), 32'(of), 32'(tbl[t].ef));
    end

    // Reset in the middle of a scan after two of four candidates
    start = 1'b1; ref_in = 8'h40; len = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h10;
    @(posedge clk); #1;
    in_data = 8'h45;
    @(posedge clk); #1;
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_outputs", {out_valid, in_ready, busy, found, out_data, out_dist, out_index}, 29'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_still_idle", {out_valid, in_ready, busy}, 3'b000);
    for (int i = 0; i < 16; i++) c[i] = 8'h00;
    c[0] = 8'h11;
    run_job("post_abort", 8'h10, 4'd1, c, 0, 0, 1'b0, od, odist, oi, of);
    check("post_abort out_data", 32'(od), 32'h11);
    check("post_abort out_dist", 32'(odist), 32'h01);
    check("post_abort out_index", 32'(oi), 32'h0);
    check("post_abort found", 32'(of), 32'h1);

    // Randomized jobs against the reference model
    for (int j = 0; j < 40; j++) begin
      logic [7:0] r;
      r = 8'($urandom);
      n = $urandom_range(0, 15);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 16; i++)
        c[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'(int'(r) + $urandom_range(0, 8) - 4);
      model(r, n, c, ed, edist, ei, ef);
      run_job($sformatf("rnd%0d", j), r, 4'(n), c, mode, $urandom_range(0, 3),
              1'($urandom_range(0, 1)), od, odist, oi, of);
      check($sformatf("rnd%0d result", j), {of, oi, odist, od}, {ef, ei, edist, ed});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
